// File: rtl/saturn_bus_controller.sv
`default_nettype none
// saturn_bus_controller: drains the bus program buffer onto the Saturn nibble bus, one bus cycle per
// 4-phase instruction cycle. Optional protocol checking: define SATURN_BUS_PROTOCOL_CHECK_EN.
module saturn_bus_controller #(
  parameter int ADDR_NIBBLES = 5,
  parameter int PROG_AW      = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clk_en,
  input  logic [3:0]         i_phases,
  input  logic [PROG_AW-1:0] i_program_address,
  input  logic [4:0]         i_program_data,
  output logic [PROG_AW-1:0] o_program_address,
  input  logic               i_no_read,
  output logic [3:0]         o_nibble,
  output logic               o_bus_busy,
  output logic [3:0]         o_bus_data,
  output logic               o_bus_strobe,
  output logic               o_bus_cmd_data,
  input  logic [3:0]         i_bus_data,
  output logic               o_error
);

  localparam int CNT_W = $clog2(ADDR_NIBBLES + 1);

  // Command codes shared with saturn_def_buscmd.v
  localparam logic [3:0] BUSCMD_PC_READ = 4'h0;
  localparam logic [3:0] BUSCMD_LOAD_PC = 4'h4;
  localparam logic [3:0] BUSCMD_RESET   = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [PROG_AW-1:0] rd_ptr, rd_ptr_nx;
  logic [4:0]         entry, entry_nx;
  logic               read_mode, read_mode_nx;
  logic [CNT_W-1:0]   addr_cnt, addr_cnt_nx;
  logic [3:0]         bus_data, bus_data_nx;
  logic [3:0]         nibble, nibble_nx;
  logic               bus_strobe, bus_strobe_nx;
  logic               bus_cmd_data, bus_cmd_data_nx;
  logic               bus_busy, bus_busy_nx;
  logic               queue_pending;
  logic               send_now;

  assign queue_pending = (rd_ptr != i_program_address);
  assign send_now      = i_clk_en && i_phases[1] && (state == SEND);

  always_comb begin
    state_nx        = state;
    rd_ptr_nx       = rd_ptr;
    entry_nx        = entry;
    read_mode_nx    = read_mode;
    addr_cnt_nx     = addr_cnt;
    bus_data_nx     = bus_data;
    nibble_nx       = nibble;
    bus_strobe_nx   = bus_strobe;
    bus_cmd_data_nx = bus_cmd_data;
    bus_busy_nx     = bus_busy;

    if (i_clk_en) begin
      case (state)
        IDLE, DONE: begin
          if (i_phases[0]) begin
            // Queued entries always take priority over read cycles
            if (queue_pending) begin
              entry_nx    = i_program_data;
              rd_ptr_nx   = rd_ptr + PROG_AW'(1);
              state_nx    = SEND;
              bus_busy_nx = 1'b1;
            end else if (read_mode && !i_no_read) begin
              state_nx = READ;
            end else begin
              state_nx = IDLE;
            end
          end else if (state == DONE) begin
            state_nx = IDLE;
          end
        end
        SEND: begin
          if (i_phases[1]) begin
            bus_data_nx     = entry[3:0];
            bus_cmd_data_nx = entry[4];
            bus_strobe_nx   = 1'b1;
            if (entry[4]) begin
              case (entry[3:0])
                BUSCMD_LOAD_PC: begin
                  addr_cnt_nx  = CNT_W'(ADDR_NIBBLES);
                  read_mode_nx = 1'b0;
                end
                BUSCMD_PC_READ: read_mode_nx = 1'b1;
                BUSCMD_RESET: begin
                  read_mode_nx = 1'b0;
                  addr_cnt_nx  = '0;
                end
                default: ;
              endcase
            end else if (addr_cnt != '0) begin
              addr_cnt_nx = addr_cnt - CNT_W'(1);
              if (addr_cnt == CNT_W'(1)) read_mode_nx = 1'b1;
            end
          end
          if (i_phases[3]) state_nx = DONE;
        end
        READ: begin
          if (i_phases[1]) begin
            bus_data_nx     = 4'h0;
            bus_cmd_data_nx = 1'b0;
            bus_strobe_nx   = 1'b1;
          end
          if (i_phases[2]) nibble_nx = i_bus_data;
          if (i_phases[3]) state_nx = DONE;
        end
        default: state_nx = IDLE;
      endcase

      if (i_phases[2]) bus_strobe_nx = 1'b0;
      if (i_phases[3]) bus_busy_nx = queue_pending;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      entry        <= '0;
      read_mode    <= 1'b0;
      addr_cnt     <= '0;
      bus_data     <= 4'h0;
      nibble       <= 4'h0;
      bus_strobe   <= 1'b0;
      bus_cmd_data <= 1'b0;
      bus_busy     <= 1'b0;
    end else begin
      state        <= state_nx;
      rd_ptr       <= rd_ptr_nx;
      entry        <= entry_nx;
      read_mode    <= read_mode_nx;
      addr_cnt     <= addr_cnt_nx;
      bus_data     <= bus_data_nx;
      nibble       <= nibble_nx;
      bus_strobe   <= bus_strobe_nx;
      bus_cmd_data <= bus_cmd_data_nx;
      bus_busy     <= bus_busy_nx;
    end
  end

  assign o_program_address = rd_ptr;
  assign o_nibble          = nibble;
  assign o_bus_busy        = bus_busy;
  assign o_bus_data        = bus_data;
  assign o_bus_strobe      = bus_strobe;
  assign o_bus_cmd_data    = bus_cmd_data;

`ifdef SATURN_BUS_PROTOCOL_CHECK_EN
  logic error_q;
  logic violation;

  // The offending entry is still sent; only the sticky flag records it
  always_comb begin
    violation = 1'b0;
    if (entry[4]) begin
      violation = (addr_cnt != '0) ||
                  !((entry[3:0] == BUSCMD_LOAD_PC) ||
                    (entry[3:0] == BUSCMD_PC_READ) ||
                    (entry[3:0] == BUSCMD_RESET));
    end else begin
      violation = (addr_cnt == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) error_q <= 1'b0;
    else if (send_now && violation) error_q <= 1'b1;
  end

`ifdef SIM
  always_ff @(posedge i_clk) begin
    if (!i_reset && send_now && violation)
      $display("saturn_bus_controller: protocol error entry=%02h rd_ptr=%0d", entry, rd_ptr);
  end
`endif

  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_saturn_bus_controller.sv
`default_nettype none
// tb_saturn_bus_controller: table vectors, directed corner sequences and randomized traffic
// checked against an instruction-cycle level model of the bus controller.
module tb_saturn_bus_controller;

  localparam logic [3:0] CMD_PC_READ = 4'h0;
  localparam logic [3:0] CMD_LOAD_PC = 4'h4;
  localparam logic [3:0] CMD_RESET   = 4'hF;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic [3:0] phases;
  logic [4:0] wr_ptr;
  logic [4:0] prog_data;
  logic [4:0] prog_rd;
  logic       no_read_in;
  logic [3:0] nibble;
  logic       busy;
  logic [3:0] bus_data;
  logic       strobe;
  logic       cmd_data;
  logic [3:0] bus_in;
  logic       error;

  logic [4:0] mem [32];
  assign prog_data = mem[prog_rd];

  saturn_bus_controller dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_clk_en          (clk_en),
    .i_phases          (phases),
    .i_program_address (wr_ptr),
    .i_program_data    (prog_data),
    .o_program_address (prog_rd),
    .i_no_read         (no_read_in),
    .o_nibble          (nibble),
    .o_bus_busy        (busy),
    .o_bus_data        (bus_data),
    .o_bus_strobe      (strobe),
    .o_bus_cmd_data    (cmd_data),
    .i_bus_data        (bus_in),
    .o_error           (error)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state, advanced once per instruction cycle
  logic [4:0] m_rd;
  logic       m_read_mode;
  int         m_addr_cnt;
  logic [3:0] m_nibble;
  logic       m_busy;
  logic       m_err;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_rd = 5'd0; m_read_mode = 1'b0; m_addr_cnt = 0;
    m_nibble = 4'h0; m_busy = 1'b0; m_err = 1'b0;
    wr_ptr = 5'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1; clk_en = 1'b0; phases = 4'b0000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic push(input logic [4:0] e);
    mem[wr_ptr] = e;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  task automatic step(input logic [3:0] ph, input bit rand_en);
    if (rand_en) begin
      repeat ($urandom_range(0, 2)) begin
        clk_en = 1'b0; phases = ph;
        @(posedge clk); #1;
      end
    end
    phases = ph; clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
  endtask

  task automatic model_apply(input logic [4:0] e);
    if (e[4]) begin
`ifdef SATURN_BUS_PROTOCOL_CHECK_EN
      if (m_addr_cnt != 0 || !(e[3:0] == CMD_LOAD_PC || e[3:0] == CMD_PC_READ || e[3:0] == CMD_RESET))
        m_err = 1'b1;
`endif
      if (e[3:0] == CMD_LOAD_PC) begin m_addr_cnt = 5; m_read_mode = 1'b0; end
      else if (e[3:0] == CMD_PC_READ) m_read_mode = 1'b1;
      else if (e[3:0] == CMD_RESET) begin m_read_mode = 1'b0; m_addr_cnt = 0; end
    end else begin
`ifdef SATURN_BUS_PROTOCOL_CHECK_EN
      if (m_addr_cnt == 0) m_err = 1'b1;
`endif
      if (m_addr_cnt > 0) begin
        m_addr_cnt--;
        if (m_addr_cnt == 0) m_read_mode = 1'b1;
      end
    end
  endtask

  task automatic instr_cycle(input logic nr, input logic [3:0] bus_nib, input bit rand_en,
                             output logic ob_strobe, output logic [3:0] ob_data, output logic ob_cmd);
    logic send, rd;
    logic [4:0] ent;
    send = (wr_ptr != m_rd);
    ent  = mem[m_rd];
    rd   = !send && m_read_mode && !nr;
    no_read_in = nr; bus_in = bus_nib;
    chk("addr_p0", 8'(prog_rd), 8'(m_rd));
    step(4'b0001, rand_en);
    if (send) begin m_rd = m_rd + 5'd1; m_busy = 1'b1; end
    chk("busy_p0", 8'(busy), 8'(m_busy));
    step(4'b0010, rand_en);
    ob_strobe = strobe; ob_data = bus_data; ob_cmd = cmd_data;
    chk("strobe_p1", 8'(strobe), 8'(send | rd));
    if (send) begin
      chk("data_send", 8'(bus_data), 8'(ent[3:0]));
      chk("cmd_send", 8'(cmd_data), 8'(ent[4]));
      model_apply(ent);
    end
    if (rd) begin
      chk("data_read", 8'(bus_data), 8'h0);
      chk("cmd_read", 8'(cmd_data), 8'h0);
    end
    step(4'b0100, rand_en);
    if (rd) m_nibble = bus_nib;
    chk("strobe_p2", 8'(strobe), 8'h0);
    chk("nibble_p2", 8'(nibble), 8'(m_nibble));
    step(4'b1000, rand_en);
    m_busy = (wr_ptr != m_rd);
    chk("busy_p3", 8'(busy), 8'(m_busy));
    chk("addr_p3", 8'(prog_rd), 8'(m_rd));
    chk("error_p3", 8'(error), 8'(m_err));
  endtask

  typedef struct {
    logic [4:0] entry;
    logic       exp_cmd;
    logic [3:0] exp_data;
    logic       exp_busy_p3;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int   wrap_slot [4];
    logic s, c;
    logic [3:0] d;

    vecs[0] = '{{1'b1, CMD_LOAD_PC}, 1'b1, CMD_LOAD_PC, 1'b1};
    vecs[1] = '{5'h05, 1'b0, 4'h5, 1'b1};
    vecs[2] = '{5'h04, 1'b0, 4'h4, 1'b1};
    vecs[3] = '{5'h03, 1'b0, 4'h3, 1'b1};
    vecs[4] = '{5'h02, 1'b0, 4'h2, 1'b1};
    vecs[5] = '{5'h01, 1'b0, 4'h1, 1'b0};
    wrap_slot[0] = 30; wrap_slot[1] = 31; wrap_slot[2] = 0; wrap_slot[3] = 1;

    for (int i = 0; i < 32; i++) mem[i] = 5'h00;
    no_read_in = 1'b0; bus_in = 4'h0; phases = 4'b0000; clk_en = 1'b0;
    wr_ptr = 5'd0;
    do_reset();

    chk("rst_strobe", 8'(strobe), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_addr", 8'(prog_rd), 8'h0);
    chk("rst_nibble", 8'(nibble), 8'h0);
    chk("rst_data", 8'(bus_data), 8'h0);
    chk("rst_cmd", 8'(cmd_data), 8'h0);
    chk("rst_error", 8'(error), 8'h0);

    // LOAD_PC followed by five address nibbles
    for (int i = 0; i < 6; i++) push(vecs[i].entry);
    for (int i = 0; i < 6; i++) begin
      instr_cycle(1'b0, 4'h0, 1'b0, s, d, c);
      chk("vec_strobe", 8'(s), 8'h1);
      chk("vec_cmd", 8'(c), 8'(vecs[i].exp_cmd));
      chk("vec_data", 8'(d), 8'(vecs[i].exp_data));
      chk("vec_busy_p3", 8'(busy), 8'(vecs[i].exp_busy_p3));
    end

    // read_mode now active: read cycle, then a suppressed one
    instr_cycle(1'b0, 4'hA, 1'b0, s, d, c);
    chk("read_strobe", 8'(s), 8'h1);
    chk("read_cmd", 8'(c), 8'h0);
    chk("read_nibble", 8'(nibble), 8'hA);
    instr_cycle(1'b1, 4'h3, 1'b0, s, d, c);
    chk("noread_strobe", 8'(s), 8'h0);
    chk("noread_nibble", 8'(nibble), 8'hA);

    // RESET then PC_READ queued while reading
    push({1'b1, CMD_RESET});
    push({1'b1, CMD_PC_READ});
    instr_cycle(1'b0, 4'h5, 1'b0, s, d, c);
    chk("q_reset_cmd", 8'(c), 8'h1);
    instr_cycle(1'b0, 4'h6, 1'b0, s, d, c);
    chk("q_pcread_cmd", 8'(c), 8'h1);
    chk("q_pcread_data", 8'(d), 8'(CMD_PC_READ));
    instr_cycle(1'b0, 4'h7, 1'b0, s, d, c);
    chk("resume_strobe", 8'(s), 8'h1);
    chk("resume_nibble", 8'(nibble), 8'h7);

    // Protocol error on a bare data nibble
    do_reset();
    push(5'h07);
    instr_cycle(1'b0, 4'h0, 1'b0, s, d, c);
`ifdef SATURN_BUS_PROTOCOL_CHECK_EN
    chk("err_set", 8'(error), 8'h1);
    instr_cycle(1'b0, 4'h0, 1'b0, s, d, c);
    instr_cycle(1'b0, 4'h0, 1'b0, s, d, c);
    chk("err_sticky", 8'(error), 8'h1);
`else
    chk("err_tied", 8'(error), 8'h0);
`endif
    do_reset();
    chk("err_cleared", 8'(error), 8'h0);

    // Pointer wrap 30,31,0,1
    for (int i = 0; i < 30; i++) push({1'b1, CMD_RESET});
    for (int i = 0; i < 30; i++) instr_cycle(1'b0, 4'h0, 1'b0, s, d, c);
    push({1'b1, CMD_RESET}); push({1'b1, CMD_PC_READ});
    push({1'b1, CMD_RESET}); push({1'b1, CMD_RESET});
    for (int i = 0; i < 4; i++) begin
      chk("wrap_slot", 8'(prog_rd), 8'(wrap_slot[i]));
      instr_cycle(1'b0, 4'h0, 1'b0, s, d, c);
      chk("wrap_strobe", 8'(s), 8'h1);
    end
    chk("wrap_final", 8'(prog_rd), 8'h2);
    chk("wrap_error", 8'(error), 8'h0);

    // Reset during phase 1 of a SEND, with read_mode previously set
    do_reset();
    push({1'b1, CMD_PC_READ});
    instr_cycle(1'b0, 4'h0, 1'b0, s, d, c);
    push({1'b1, CMD_LOAD_PC});
    no_read_in = 1'b0;
    step(4'b0001, 1'b0);
    phases = 4'b0010; clk_en = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; clk_en = 1'b0;
    chk("midrst_strobe", 8'(strobe), 8'h0);
    chk("midrst_addr", 8'(prog_rd), 8'h0);
    chk("midrst_busy", 8'(busy), 8'h0);
    model_reset();
    instr_cycle(1'b0, 4'h9, 1'b0, s, d, c);
    chk("midrst_noread", 8'(s), 8'h0);

    // Randomized traffic with clock-enable gaps
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int k;
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        if (5'(wr_ptr - m_rd) < 5'd16) begin
          int r;
          r = $urandom_range(0, 9);
          if (r < 2)      push({1'b1, CMD_LOAD_PC});
          else if (r < 3) push({1'b1, CMD_PC_READ});
          else if (r < 4) push({1'b1, CMD_RESET});
          else if (r < 5) push({1'b1, 4'($urandom_range(0, 15))});
          else            push({1'b0, 4'($urandom_range(0, 15))});
        end
      end
      instr_cycle(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 1'b1, s, d, c);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/saturn_bus_controller.md
Name: saturn_bus_controller

Overview:
Drains the bus program buffer filled by the control unit and drives the Saturn nibble bus, one bus cycle per 4-phase instruction cycle. Queued command/data entries go out first. When the queue is empty and read mode is active, it performs nibble read cycles. It feeds the fetched nibbles back to the control unit and decoder, and asserts bus-busy while queued entries remain. Command encodings come from saturn_def_buscmd.v (BUSCMD_LOAD_PC, BUSCMD_PC_READ, BUSCMD_RESET).

Parameters:
ADDR_NIBBLES, 5, number of data nibbles following BUSCMD_LOAD_PC
PROG_AW, 5, program buffer address width (32 entries)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_clk_en  in  1  clock enable; all state advances only when high
i_phases  in  4  one-hot phase (bit n = phase n)
i_program_address  in  5  control unit write pointer (next free slot)
i_program_data  in  5  buffer entry at o_program_address: {is_cmd, nibble}
o_program_address  out  5  read pointer into program buffer
i_no_read  in  1  suppress read cycle this instruction cycle
o_nibble  out  4  last nibble read from bus
o_bus_busy  out  1  queued entries pending or bus cycle in progress
o_bus_data  out  4  nibble driven on bus
o_bus_strobe  out  1  bus strobe, one enabled clock wide
o_bus_cmd_data  out  1  1 = command nibble, 0 = data/read
i_bus_data  in  4  nibble returned by bus devices
o_error  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0; rd_ptr=0; state=IDLE; read_mode=0; addr_cnt=0. i_reset wins over any same-cycle event. Mid-cycle reset drops strobe the next clock; no partial nibble is latched.
- States:
  - IDLE: waiting for the start of an instruction cycle.
  - SEND: driving one queued entry onto the bus.
  - READ: performing one nibble read cycle.
  - DONE: closing out the instruction cycle.
- Phase 0, IDLE:
  - If rd_ptr != i_program_address: latch entry, rd_ptr+1 (wraps 31->0), go to SEND, o_bus_busy=1.
  - Else if read_mode && !i_no_read: go to READ.
  - Else stay in IDLE.
- Phase 1:
  - SEND: o_bus_data=entry[3:0], o_bus_cmd_data=entry[4], o_bus_strobe=1.
  - READ: o_bus_data=0, o_bus_cmd_data=0, o_bus_strobe=1.
- Phase 2: strobe=0. In READ, o_nibble <= i_bus_data; o_nibble stays valid until the next read.
- Phase 3: go to DONE, then IDLE. o_bus_busy <= (rd_ptr != i_program_address).
- Latency: entry written in cycle N appears on the bus at phase 1 of the next instruction cycle. Strictly one entry per instruction cycle.
- Command semantics (when sent):
  - LOAD_PC: addr_cnt=ADDR_NIBBLES, read_mode=0.
  - Each data nibble while addr_cnt>0 decrements addr_cnt; reaching 0 sets read_mode=1.
  - PC_READ: read_mode=1.
  - RESET: read_mode=0, addr_cnt=0.
- Empty queue with read_mode=0: no strobe, o_bus_busy=0.
- Pointer equality always means empty. The producer must not get 32 entries ahead; overrun is undetected.
- Phases advance only on i_clk_en. A held-low i_clk_en freezes state and outputs, and strobe remains as last driven.

Optional Feature:
SATURN_BUS_PROTOCOL_CHECK_EN.
- Defined: o_error set (sticky until reset) on any of:
  - a data entry sent while addr_cnt==0;
  - a command entry sent while addr_cnt>0;
  - an unknown command code.
- On error: the offending entry is still sent, and SIM builds $display the entry and rd_ptr.
- Undefined: o_error tied 0 and no checking logic is present.

Test Plan:
- Reset, then entries {1,LOAD_PC},0x5,0x4,0x3,0x2,0x1 written at ptr 0..5 -> six consecutive strobes with cmd_data 1,0,0,0,0,0 and data LOAD_PC,5,4,3,2,1. read_mode=1 after the 6th. o_bus_busy falls at phase 3 of the 6th cycle.
- Empty queue, read_mode=1, i_bus_data=0xA -> strobe with cmd_data=0 in phase 1, o_nibble=0xA after phase 2. With i_no_read=1 -> no strobe, o_nibble unchanged.
- Queue {1,RESET},{1,PC_READ} while reading -> no read strobe between them. Reads resume on the cycle after PC_READ is sent.
- Start rd_ptr=30, write 4 entries -> sent from slots 30,31,0,1; o_program_address wraps to 2; no error.
- With SATURN_BUS_PROTOCOL_CHECK_EN, a data entry 0x7 with addr_cnt=0 -> o_error=1 and stays 1 until i_reset. Without the macro -> o_error=0.
- i_reset asserted in phase 1 of a SEND -> next clock strobe=0, o_program_address=0, o_bus_busy=0, read_mode=0.
